div_unit: RTL and testbench

Multi-cycle integer divide unit for the execute stage, sitting beside the ALU and fed from the same operand muxes. It implements the RV32M DIV, DIVU, REM and REMU operations with a radix-2 restoring algorithm, one quotient bit per cycle. The hazard unit holds the pipeline while `busy` is high and captures `DIVout` into EX/MEM on the `done` pulse.

---
 rtl/div_unit_if.sv | 27 ++
 rtl/div_unit.sv | 138 +++++++++++++
 tb/tb_div_unit.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// div_unit_if: operand/op request and result bundle between the execute stage and div_unit.
// Latency: none, wiring only.
// Backpressure: the requester stalls on busy; a start presented while the unit is in RUN is dropped.
interface div_unit_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic                  flush;
   logic [1:0]            DIVControl;
   logic [DATA_WIDTH-1:0] DIVop1;
   logic [DATA_WIDTH-1:0] DIVop2;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] DIVout;

   // execute-stage side: issues requests, observes status and result
   modport master (
      output start, flush, DIVControl, DIVop1, DIVop2,
      input  busy, done, DIVout
   );

   // divider side
   modport slave (
      input  start, flush, DIVControl, DIVop1, DIVop2,
      output busy, done, DIVout
   );
endinterface

// File: rtl/div_unit.sv
// div_unit: RV32M DIV/DIVU/REM/REMU, radix-2 restoring, one quotient bit per cycle.
// Latency: DATA_WIDTH+1 cycles from start to done; with DIV_EARLY_OUT_EN, x/0 and MIN/-1 finish in 1.
// Backpressure: busy holds the pipeline; start is ignored while busy; flush aborts with no done.
module div_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic      clk,
   input  logic      rst_n,
   div_unit_if.slave bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W + 1);
   localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state_q, state_d;
   logic [W:0]     rem_q;       // extra MSB carries the trial-subtract sign
   logic [W-1:0]   quo_q;       // starts as dividend magnitude, fills with quotient bits
   logic [W-1:0]   dvs_q;       // divisor magnitude
   logic [W-1:0]   dvd_q;       // raw dividend, returned by REM/REMU on divide-by-zero
   logic [CW-1:0]  cnt_q;
   logic           sel_rem_q, qneg_q, rneg_q, div0_q, ovf_q;
   logic [W-1:0]   divout_q;

   // operand decode on the accept edge; signed ops take magnitudes
   logic           is_signed, op1_neg, op2_neg, in_div0, in_ovf, accept, last;
   logic [W-1:0]   mag1, mag2;
   assign is_signed = ~bus.DIVControl[0];
   assign op1_neg   = is_signed & bus.DIVop1[W-1];
   assign op2_neg   = is_signed & bus.DIVop2[W-1];
   assign mag1      = op1_neg ? -bus.DIVop1 : bus.DIVop1;
   assign mag2      = op2_neg ? -bus.DIVop2 : bus.DIVop2;
   assign in_div0   = (bus.DIVop2 == '0);
   assign in_ovf    = is_signed & (bus.DIVop1 == MOST_NEG) & (bus.DIVop2 == '1);
   assign accept    = bus.start & ~bus.flush & (state_q != RUN);
   assign last      = (cnt_q == CW'(1));

   // one restoring step: shift {rem,quo}, trial subtract, keep if non-negative
   logic [W:0]     rem_sh, trial, rem_nxt;
   logic [W-1:0]   quo_nxt;
   always_comb begin
      rem_sh  = (rem_q << 1) | {{W{1'b0}}, quo_q[W-1]};
      trial   = rem_sh - {1'b0, dvs_q};
      rem_nxt = trial[W] ? rem_sh : trial;
      quo_nxt = {quo_q[W-2:0], ~trial[W]};
   end

   // sign correction and RISC-V special results
   function automatic logic [W-1:0] finalize(
      input logic         sel_rem,
      input logic [W-1:0] quo,
      input logic [W-1:0] rem,
      input logic         qneg,
      input logic         rneg,
      input logic         div0,
      input logic         ovf,
      input logic [W-1:0] dvd
   );
      if (div0)         return sel_rem ? dvd : '1;
      else if (ovf)     return sel_rem ? '0 : MOST_NEG;
      else if (sel_rem) return rneg ? -rem : rem;
      else              return qneg ? -quo : quo;
   endfunction

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // next-state logic; flush overrides everything including a coincident start
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (accept) begin
`ifdef DIV_EARLY_OUT_EN
               state_d = (in_div0 | in_ovf) ? DONE : RUN;
`else
               state_d = RUN;
`endif
            end
         end
         RUN:     if (last) state_d = DONE;
         default: state_d = IDLE;
      endcase
      if (bus.flush) state_d = IDLE;
   end

   // status outputs decoded from state
   always_comb begin
      bus.busy = (state_q == RUN);
      bus.done = (state_q == DONE);
   end
   assign bus.DIVout = divout_q;

   // datapath: load on accept, iterate in RUN, register the result on the edge into DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         dvd_q     <= '0;
         cnt_q     <= '0;
         sel_rem_q <= 1'b0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         div0_q    <= 1'b0;
         ovf_q     <= 1'b0;
         divout_q  <= '0;
      end else if (accept) begin
         rem_q     <= '0;
         quo_q     <= mag1;
         dvs_q     <= mag2;
         dvd_q     <= bus.DIVop1;
         cnt_q     <= CW'(W);
         sel_rem_q <= bus.DIVControl[1];
         qneg_q    <= op1_neg ^ op2_neg;
         rneg_q    <= op1_neg;
         div0_q    <= in_div0;
         ovf_q     <= in_ovf;
`ifdef DIV_EARLY_OUT_EN
         if (in_div0 | in_ovf)
            divout_q <= finalize(bus.DIVControl[1], '0, '0, 1'b0, 1'b0,
                                 in_div0, in_ovf, bus.DIVop1);
`endif
      end else if (state_q == RUN && !bus.flush) begin
         rem_q <= rem_nxt;
         quo_q <= quo_nxt;
         cnt_q <= cnt_q - CW'(1);
         if (last)
            divout_q <= finalize(sel_rem_q, quo_nxt, rem_nxt[W-1:0], qneg_q, rneg_q,
                                 div0_q, ovf_q, dvd_q);
      end
   end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vectors with hand-computed results for div_unit.
// Latency: checks done/busy cycle positions relative to the start edge.
// Backpressure: exercises start-while-busy, flush abort, flush+start, and back-to-back starts.
module tb_div_unit;
   localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
`ifdef DIV_EARLY_OUT_EN
   localparam int SPC = 1;
`else
   localparam int SPC = 33;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   div_unit_if #(.DATA_WIDTH(32)) bus ();
   div_unit #(.DATA_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   // single comparison point
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // present a request for one cycle, then scramble operands to prove they were latched
   task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.start = 1'b1; bus.DIVControl = op; bus.DIVop1 = a; bus.DIVop2 = b;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.DIVop1 = ~a; bus.DIVop2 = b + 32'd3; bus.DIVControl = ~op;
   endtask

   // walk cycles 1.. after the start edge; returns sampled in the done cycle
   task automatic wait_done(input string tag, input logic [31:0] exp, input int exp_cyc);
      int n = 1, nbusy = 0, overlap = 0;
      while (!bus.done && n < 100) begin
         if (bus.busy) nbusy++;
         @(posedge clk); #1;
         n++;
      end
      if (bus.busy && bus.done) overlap++;
      check({tag, "_cyc"}, n, exp_cyc);
      check({tag, "_busy"}, nbusy, exp_cyc - 1);
      check({tag, "_ovl"}, overlap, 0);
      check({tag, "_res"}, bus.DIVout, exp);
   endtask

   task automatic op(input string tag, input logic [1:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input int cyc);
      launch(o, a, b);
      wait_done(tag, exp, cyc);
   endtask

   initial begin
      int ndone;
      bus.start = 1'b0; bus.flush = 1'b0; bus.DIVControl = 2'b00;
      bus.DIVop1 = '0; bus.DIVop2 = '0;
      #12;
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_out", bus.DIVout, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      op("div_100_7",   OP_DIV,  32'd100,      32'd7,        32'd14,       33);
      op("rem_100_7",   OP_REM,  32'd100,      32'd7,        32'd2,        33);
      op("rem_m7_2",    OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
      op("div_m7_2",    OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
      op("div_7_m2",    OP_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
      op("rem_7_m2",    OP_REM,  32'd7,        32'hFFFFFFFE, 32'd1,        33);
      op("div_m100_m7", OP_DIV,  32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       33);
      op("rem_m100_m7", OP_REM,  32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 33);
      op("divu_max_2",  OP_DIVU, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 33);
      op("remu_max_2",  OP_REMU, 32'hFFFFFFFF, 32'd2,        32'd1,        33);
      op("div_by0",     OP_DIV,  32'h12345678, 32'd0,        32'hFFFFFFFF, SPC);
      op("rem_by0",     OP_REM,  32'h12345678, 32'd0,        32'h12345678, SPC);
      op("divu_by0",    OP_DIVU, 32'h12345678, 32'd0,        32'hFFFFFFFF, SPC);
      op("remu_by0",    OP_REMU, 32'h12345678, 32'd0,        32'h12345678, SPC);
      op("div_ovf",     OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPC);
      op("rem_ovf",     OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'd0,        SPC);
      op("divu_nonovf", OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0,        33);
      op("remu_nonovf", OP_REMU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
      op("div_ref",     OP_DIV,  32'd100,      32'd7,        32'd14,       33);

      // start while busy is ignored: second request mid-run must not restart the count
      launch(OP_DIV, 32'd1000, 32'd10);
      repeat (4) begin @(posedge clk); #1; end
      launch(OP_DIV, 32'd50, 32'd5);
      wait_done("ign_start", 32'd100, 33 - 5);

      // flush during cycle 10 of a run
      @(posedge clk); #1;
      launch(OP_DIV, 32'd999, 32'd3);
      repeat (9) begin @(posedge clk); #1; end
      bus.flush = 1'b1;
      @(posedge clk); #1;
      bus.flush = 1'b0;
      check("flush_busy", {31'd0, bus.busy}, 32'd0);
      ndone = 0;
      repeat (40) begin
         if (bus.done) ndone++;
         @(posedge clk); #1;
      end
      check("flush_nodone", ndone, 0);
      check("flush_keep", bus.DIVout, 32'd100);

      // start together with flush is dropped
      bus.start = 1'b1; bus.flush = 1'b1; bus.DIVControl = OP_DIV;
      bus.DIVop1 = 32'd8; bus.DIVop2 = 32'd2;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.flush = 1'b0;
      ndone = 0;
      repeat (40) begin
         if (bus.done || bus.busy) ndone++;
         @(posedge clk); #1;
      end
      check("flush_start_drop", ndone, 0);

      // back-to-back: second start issued in the DONE cycle
      op("b2b_first",  OP_DIV, 32'd1000, 32'd10, 32'd100, 33);
      op("b2b_second", OP_REM, 32'd1000, 32'd7,  32'd6,   33);

      // asynchronous reset mid-run
      launch(OP_DIVU, 32'd77, 32'd7);
      repeat (5) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", {31'd0, bus.busy}, 32'd0);
      check("arst_done", {31'd0, bus.done}, 32'd0);
      check("arst_out", bus.DIVout, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      op("post_rst", OP_DIVU, 32'd77, 32'd7, 32'd11, 33);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
